// File: rtl/shared_bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package shared_bus_arbiter_pkg;

    // Arbiter control states: waiting for a decision, or a grant in progress.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // Hold counter width: wide enough to reach the limit, never narrower than one bit.
    function automatic int hold_count_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/shared_bus_arbiter_priority.sv
// Combinational fixed-priority picker: the lowest set request bit wins.
module Priority_Arbiter #(
    parameter int WORD_WIDTH = 4
) (
    input  logic [WORD_WIDTH-1:0] requests,
    output logic [WORD_WIDTH-1:0] grant
);

    assign grant[0] = requests[0];

    // A bit wins only if no lower-numbered bit is requesting.
    generate
        for (genvar gi = 1; gi < WORD_WIDTH; gi++) begin : g_pick
            assign grant[gi] = requests[gi] & ~(|requests[gi-1:0]);
        end
    endgenerate

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter with grant hold, optional hold limit and one dead
// cycle between grants for bus turnaround. All outputs are registered.
module shared_bus_arbiter
    import shared_bus_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = 4,
    parameter int HOLD_LIMIT = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [WORD_WIDTH-1:0]         requests,
    input  logic                          done,
    output logic [WORD_WIDTH-1:0]         grant,
    output logic                          grant_valid,
    output logic [$clog2(WORD_WIDTH)-1:0] grant_index,
    output logic                          preempted
);

    localparam int IDX_W = $clog2(WORD_WIDTH);
    localparam int HC_W  = hold_count_width(HOLD_LIMIT);
    localparam logic [HC_W-1:0]       HOLD_LIMIT_C = HC_W'(HOLD_LIMIT);
    localparam logic [HC_W-1:0]       HC_ONE       = HC_W'(1);
    localparam logic [WORD_WIDTH-1:0] LSB_ONE      = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

    arb_state_e              state_q, state_d;
    logic [WORD_WIDTH-1:0]   grant_q, grant_d;
    logic [WORD_WIDTH-1:0]   mask_q, mask_d;
    logic [HC_W-1:0]         hold_count_q, hold_count_d;
    logic                    preempted_q, preempted_d;
    logic                    grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]        grant_index_q, grant_index_d;

    logic [WORD_WIDTH-1:0]   pick_masked;
    logic [WORD_WIDTH-1:0]   pick_any;
    logic                    owner_present;
    logic                    limit_hit;
    logic                    grant_end;

    // Round-robin = masked pick first, unmasked pick as the wrap-around fallback.
    Priority_Arbiter #(.WORD_WIDTH(WORD_WIDTH)) u_pick_masked (
        .requests (requests & mask_q),
        .grant    (pick_masked)
    );

    Priority_Arbiter #(.WORD_WIDTH(WORD_WIDTH)) u_pick_any (
        .requests (requests),
        .grant    (pick_any)
    );

    assign owner_present = |(requests & grant_q);
    assign limit_hit     = (HOLD_LIMIT != 0) && (hold_count_q == HOLD_LIMIT_C);
    assign grant_end     = (state_q == ST_BUSY) && (done || !owner_present || limit_hit);

    // State and output registers; reset forces an idle, fully-unmasked arbiter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            mask_q        <= '1;
            hold_count_q  <= '0;
            preempted_q   <= 1'b0;
            grant_valid_q <= 1'b0;
            grant_index_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            mask_q        <= mask_d;
            hold_count_q  <= hold_count_d;
            preempted_q   <= preempted_d;
            grant_valid_q <= grant_valid_d;
            grant_index_q <= grant_index_d;
        end
    end

    // Next state: leave IDLE on any request, leave BUSY when the grant ends.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (|requests) state_d = ST_BUSY;
            ST_BUSY: if (grant_end) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant, rotation mask, hold counter and preemption pulse for the next cycle.
    always_comb begin
        grant_d      = grant_q;
        mask_d       = mask_q;
        hold_count_d = hold_count_q;
        preempted_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                grant_d      = '0;
                hold_count_d = '0;
                if (|requests) begin
                    grant_d      = (|pick_masked) ? pick_masked : pick_any;
                    hold_count_d = HC_ONE;
                end
            end
            ST_BUSY: begin
                if (grant_end) begin
                    grant_d      = '0;
                    // Keep only bits strictly above the owner enabled for next time.
                    mask_d       = ~({grant_q[WORD_WIDTH-2:0], 1'b0} - LSB_ONE);
                    hold_count_d = '0;
                    preempted_d  = limit_hit && !done && owner_present;
                end else if (hold_count_q != '1) begin
                    hold_count_d = hold_count_q + HC_ONE;
                end
            end
            default: begin
                grant_d      = '0;
                hold_count_d = '0;
            end
        endcase
    end

    // Binary index and valid flag derived from the next grant so they register in step.
    always_comb begin
        grant_valid_d = |grant_d;
        grant_index_d = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (grant_d[i]) grant_index_d = grant_index_d | IDX_W'(i);
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_index = grant_index_q;
    assign preempted   = preempted_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Bench for shared_bus_arbiter: directed scenarios plus random traffic,
// checked every cycle against a circular-search reference model.
module tb_shared_bus_arbiter;

    localparam int W = 4;
    localparam int L = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] requests_a, requests_b;
    logic       done_a, done_b;
    logic [3:0] grant_a, grant_b;
    logic       valid_a, valid_b;
    logic [1:0] index_a, index_b;
    logic       pre_a, pre_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state per DUT: owner (-1 = none), grant length, last owner.
    int m_owner[2];
    int m_len[2];
    int m_last[2];
    bit m_pre[2];

    always #5 clock = ~clock;

    shared_bus_arbiter #(.WORD_WIDTH(W), .HOLD_LIMIT(L)) u_dut_a (
        .clock       (clock),
        .reset       (reset),
        .requests    (requests_a),
        .done        (done_a),
        .grant       (grant_a),
        .grant_valid (valid_a),
        .grant_index (index_a),
        .preempted   (pre_a)
    );

    shared_bus_arbiter #(.WORD_WIDTH(W), .HOLD_LIMIT(0)) u_dut_b (
        .clock       (clock),
        .reset       (reset),
        .requests    (requests_b),
        .done        (done_b),
        .grant       (grant_b),
        .grant_valid (valid_b),
        .grant_index (index_b),
        .preempted   (pre_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_len[k]   = 0;
            m_last[k]  = -1;
            m_pre[k]   = 1'b0;
        end
    endtask

    // One clock edge of the arbitration rules for model k.
    task automatic model_step(input int k, input logic [3:0] req, input logic dn, input int limit);
        bit found;
        bit lim;
        bit drop;
        int c;
        found    = 1'b0;
        m_pre[k] = 1'b0;
        if (m_owner[k] < 0) begin
            for (int s = 1; s <= W && !found; s++) begin
                c = (m_last[k] + s + W) % W;
                if (req[c]) begin
                    found      = 1'b1;
                    m_owner[k] = c;
                    m_len[k]   = 1;
                end
            end
        end else begin
            lim  = (limit != 0) && (m_len[k] == limit);
            drop = !req[m_owner[k]];
            if (dn || drop || lim) begin
                m_pre[k]   = lim && !dn && !drop;
                m_last[k]  = m_owner[k];
                m_owner[k] = -1;
                m_len[k]   = 0;
            end else begin
                m_len[k]++;
            end
        end
    endtask

    function automatic logic [3:0] exp_grant(input int k);
        logic [3:0] g;
        g = '0;
        if (m_owner[k] >= 0) g[m_owner[k]] = 1'b1;
        return g;
    endfunction

    function automatic logic [1:0] exp_index(input int k);
        return (m_owner[k] >= 0) ? 2'(m_owner[k]) : 2'd0;
    endfunction

    task automatic compare_all();
        check("grant_a", 32'(grant_a), 32'(exp_grant(0)));
        check("valid_a", 32'(valid_a), 32'(m_owner[0] >= 0));
        check("index_a", 32'(index_a), 32'(exp_index(0)));
        check("preempted_a", 32'(pre_a), 32'(m_pre[0]));
        check("grant_b", 32'(grant_b), 32'(exp_grant(1)));
        check("valid_b", 32'(valid_b), 32'(m_owner[1] >= 0));
        check("preempted_b", 32'(pre_b), 32'(m_pre[1]));
    endtask

    // Drive inputs at the falling edge, step the model at the rising edge, compare at the next falling edge.
    task automatic cycle(input logic [3:0] ra, input logic da, input logic [3:0] rb, input logic db);
        requests_a = ra;
        done_a     = da;
        requests_b = rb;
        done_b     = db;
        @(posedge clock);
        model_step(0, ra, da, L);
        model_step(1, rb, db, 0);
        @(negedge clock);
        cyc++;
        compare_all();
    endtask

    task automatic cyc_a(input logic [3:0] ra, input logic da);
        cycle(ra, da, 4'b0000, 1'b0);
    endtask

    task automatic do_reset();
        requests_a = '0;
        done_a     = 1'b0;
        requests_b = '0;
        done_b     = 1'b0;
        reset      = 1'b1;
        model_reset();
        #1;
        check("rst_grant", 32'(grant_a), 32'h0);
        check("rst_valid", 32'(valid_a), 32'h0);
        check("rst_index", 32'(index_a), 32'h0);
        check("rst_preempted", 32'(pre_a), 32'h0);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] rot_exp [5];
        logic [3:0] ra;
        logic [3:0] rb;
        rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        reset      = 1'b1;
        requests_a = '0;
        done_a     = 1'b0;
        requests_b = '0;
        done_b     = 1'b0;
        model_reset();
        @(negedge clock);
        check("init_grant", 32'(grant_a), 32'h0);
        check("init_valid", 32'(valid_a), 32'h0);
        reset = 1'b0;

        // Basic grant and turnaround.
        do_reset();
        cyc_a(4'b0101, 1'b0);
        check("basic_first", 32'(grant_a), 32'h1);
        cyc_a(4'b0101, 1'b0);
        cyc_a(4'b0101, 1'b0);
        cyc_a(4'b0101, 1'b1);
        check("basic_dead", 32'(grant_a), 32'h0);
        cyc_a(4'b0101, 1'b0);
        check("basic_second", 32'(grant_a), 32'h4);
        check("basic_index", 32'(index_a), 32'h2);

        // Rotation across all four requesters.
        do_reset();
        for (int g = 0; g < 5; g++) begin
            cyc_a(4'b1111, 1'b0);
            check("rot_grant", 32'(grant_a), 32'(rot_exp[g]));
            cyc_a(4'b1111, 1'b0);
            cyc_a(4'b1111, 1'b1);
            check("rot_idle", 32'(grant_a), 32'h0);
        end

        // Hold limit preemption, then done coinciding with the limit.
        do_reset();
        for (int i = 0; i < 5; i++) cyc_a(4'b0010, 1'b0);
        check("hold_end", 32'(grant_a), 32'h0);
        check("hold_preempt", 32'(pre_a), 32'h1);
        cyc_a(4'b0010, 1'b0);
        check("hold_regrant", 32'(grant_a), 32'h2);
        for (int i = 0; i < 3; i++) cyc_a(4'b0010, 1'b0);
        cyc_a(4'b0010, 1'b1);
        check("hold_done_end", 32'(grant_a), 32'h0);
        check("hold_done_nopre", 32'(pre_a), 32'h0);

        // Owner drops its request; next grant wraps to the lowest pending bit.
        do_reset();
        cyc_a(4'b1000, 1'b0);
        check("drop_owner", 32'(grant_a), 32'h8);
        cyc_a(4'b1000, 1'b0);
        cyc_a(4'b0110, 1'b0);
        check("drop_end", 32'(grant_a), 32'h0);
        check("drop_nopre", 32'(pre_a), 32'h0);
        cyc_a(4'b0110, 1'b0);
        check("drop_wrap", 32'(grant_a), 32'h2);

        // Unlimited hold on the second instance while the first sees random traffic.
        do_reset();
        ra = 4'b0000;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 2) == 0) ra = 4'($urandom_range(0, 15));
            cycle(ra, ($urandom_range(0, 4) == 0), 4'b0001, 1'b0);
            check("unlim_grant", 32'(grant_b), 32'h1);
            check("unlim_nopre", 32'(pre_b), 32'h0);
        end

        // Random traffic on both instances.
        rb = 4'b0000;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) ra = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rb = 4'($urandom_range(0, 15));
            cycle(ra, ($urandom_range(0, 4) == 0), rb, ($urandom_range(0, 5) == 0));
        end

        // Asynchronous reset asserted mid-cycle while a grant is active.
        cyc_a(4'b1111, 1'b0);
        cyc_a(4'b1111, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("async_grant", 32'(grant_a), 32'h0);
        check("async_valid", 32'(valid_a), 32'h0);
        check("async_index", 32'(index_a), 32'h0);
        check("async_preempted", 32'(pre_a), 32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        cyc_a(4'b1111, 1'b0);
        check("async_first", 32'(grant_a), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
